str_stream_engine: RTL and testbench

Synthesizable byte-stream string processor. It buffers one string of up to MAX_LEN ASCII characters from a valid/ready input stream. It then either streams the string back out transformed (pass-through, reversed, or rotated left by k), or checks it for palindrome; optional case folding applies in every mode. It sits between a character source (UART/host FIFO) and downstream consumers as the hardware counterpart of the team's string-handling routines.

---
 rtl/str_stream_engine.sv | 209 ++++++++++++++++++++
 tb/tb_str_stream_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/str_stream_engine.sv
// -----------------------------------------------------------------------------
// str_stream_engine
//   Buffers one ASCII string (up to MAX_LEN bytes) from a valid/ready input
//   stream, then either streams it back out (pass, reverse, rotate-left by k)
//   or checks it for palindrome. Optional case folding is applied on write.
//
// Handshake: a byte moves on a side exactly on a rising edge where that
//   side's valid and ready are both 1. Input and output phases never overlap:
//   in_ready is 1 only in LOAD, out_valid is 1 only in EMIT.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last   input byte stream
//   mode, case_fold, rot_k      per-string controls, latched on first byte
//   out_valid/out_ready/out_data/out_last  output byte stream
//   len_o, overflow             length / truncation flag of last string
//   pal_valid, is_pal           palindrome result strobe and held result
// -----------------------------------------------------------------------------
module str_stream_engine #(
    parameter int MAX_LEN = 32,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    input  logic [1:0]    mode,
    input  logic          case_fold,
    input  logic [LW-1:0] rot_k,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic [LW-1:0] len_o,
    output logic          overflow,
    output logic          pal_valid,
    output logic          is_pal
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

    typedef enum logic [1:0] {
        S_LOAD     = 2'd0,
        S_ROT_PREP = 2'd1,
        S_EMIT     = 2'd2,
        S_CHECK    = 2'd3
    } state_t;

    state_t        r_state;
    logic [7:0]    r_buf [MAX_LEN];
    logic [LW-1:0] r_wr_ptr;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_k;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_j;
    logic [AW-1:0] r_i;
    logic [1:0]    r_mode;
    logic          r_fold;
    logic          r_first;      // next accepted byte starts a new string
    logic          r_ovf_pend;   // bytes dropped so far in the current string
    logic          r_overflow;
    logic          r_pal_valid;
    logic          r_is_pal;

    logic          w_accept;
    logic          w_full;
    logic          w_fold;
    logic [1:0]    w_mode;
    logic [7:0]    w_byte;
    logic [LW-1:0] w_len_new;
    logic          w_ovf_now;
    logic          w_emit_last;
    logic [LW-1:0] w_half;
    logic [AW-1:0] w_hi_idx;
    logic          w_rd_wrap;

    // Controls come straight from the ports on the first byte, since the
    // latched copies only become valid one edge later.
    assign w_mode    = r_first ? mode : r_mode;
    assign w_fold    = r_first ? case_fold : r_fold;
    assign w_accept  = in_valid && (r_state == S_LOAD);
    assign w_full    = (r_wr_ptr == MAX_L);
    assign w_byte    = (w_fold && in_data >= 8'h41 && in_data <= 8'h5A) ? (in_data | 8'h20) : in_data;
    assign w_len_new = w_full ? MAX_L : (r_wr_ptr + LW'(1));
    // The pending flag is stale on a string's first byte.
    assign w_ovf_now = (!r_first && r_ovf_pend) || w_full;

    assign w_emit_last = (LW'(r_j) == (r_len - LW'(1)));
    assign w_half      = r_len >> 1;
    assign w_hi_idx    = AW'(r_len - LW'(1)) - r_i;
    assign w_rd_wrap   = (LW'(r_rd_ptr) == (r_len - LW'(1)));

    assign in_ready  = (r_state == S_LOAD);
    assign out_valid = (r_state == S_EMIT);
    assign out_data  = (r_state == S_EMIT) ? r_buf[r_rd_ptr] : 8'h00;
    assign out_last  = (r_state == S_EMIT) && w_emit_last;
    assign len_o     = r_len;
    assign overflow  = r_overflow;
    assign pal_valid = r_pal_valid;
    assign is_pal    = r_is_pal;

    // String storage carries no reset; it is only read after being written.
    always_ff @(posedge clk) begin
        if (w_accept && !w_full) begin
            r_buf[r_wr_ptr[AW-1:0]] <= w_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_LOAD;
            r_wr_ptr    <= '0;
            r_len       <= '0;
            r_k         <= '0;
            r_rd_ptr    <= '0;
            r_j         <= '0;
            r_i         <= '0;
            r_mode      <= 2'd0;
            r_fold      <= 1'b0;
            r_first     <= 1'b1;
            r_ovf_pend  <= 1'b0;
            r_overflow  <= 1'b0;
            r_pal_valid <= 1'b0;
            r_is_pal    <= 1'b0;
        end else begin
            r_pal_valid <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        if (r_first) begin
                            r_mode     <= mode;
                            r_fold     <= case_fold;
                            r_k        <= rot_k;
                            r_ovf_pend <= 1'b0;
                            r_overflow <= 1'b0;
                        end
                        if (w_full) begin
                            r_ovf_pend <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + LW'(1);
                        end
                        if (in_last) begin
                            r_len      <= w_len_new;
                            r_overflow <= w_ovf_now;
                            r_wr_ptr   <= '0;
                            r_first    <= 1'b1;
                            r_j        <= '0;
                            r_i        <= '0;
                            r_rd_ptr   <= '0;
                            case (w_mode)
                                2'd0: r_state <= S_EMIT;
                                2'd1: begin
                                    r_state  <= S_EMIT;
                                    r_rd_ptr <= AW'(w_len_new - LW'(1));
                                end
                                2'd2: r_state <= S_ROT_PREP;
                                default: r_state <= S_CHECK;
                            endcase
                        end else begin
                            r_first <= 1'b0;
                        end
                    end
                end
                // Repeated subtraction reduces rot_k modulo len, one step per cycle.
                S_ROT_PREP: begin
                    if (r_k >= r_len) begin
                        r_k <= r_k - r_len;
                    end else begin
                        r_rd_ptr <= AW'(r_k);
                        r_state  <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (w_emit_last) begin
                            r_state <= S_LOAD;
                        end else begin
                            r_j <= r_j + AW'(1);
                            if (r_mode == 2'd1) begin
                                r_rd_ptr <= r_rd_ptr - AW'(1);
                            end else if (w_rd_wrap) begin
                                r_rd_ptr <= '0;
                            end else begin
                                r_rd_ptr <= r_rd_ptr + AW'(1);
                            end
                        end
                    end
                end
                default: begin  // S_CHECK
                    if (LW'(r_i) >= w_half) begin
                        r_is_pal    <= 1'b1;
                        r_pal_valid <= 1'b1;
                        r_state     <= S_LOAD;
                    end else if (r_buf[r_i] != r_buf[w_hi_idx]) begin
                        r_is_pal    <= 1'b0;
                        r_pal_valid <= 1'b1;
                        r_state     <= S_LOAD;
                    end else begin
                        r_i <= r_i + AW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_str_stream_engine.sv
// Directed bench for str_stream_engine. Two instances: the default MAX_LEN=32
// one and a MAX_LEN=8 one for truncation; use8 selects which one the shared
// stimulus is steered to. Inputs change and outputs are sampled on negedge.
module tb_str_stream_engine;

  localparam int LW  = 6;
  localparam int LW8 = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_last, case_fold_r, out_ready;
  logic [7:0] in_data;
  logic [1:0] mode_r;
  logic [LW-1:0] rot_k_r;
  logic use8;

  logic a_in_ready, a_out_valid, a_out_last, a_ovf, a_pal_valid, a_is_pal;
  logic [7:0] a_out_data;
  logic [LW-1:0] a_len;
  logic b_in_ready, b_out_valid, b_out_last, b_ovf, b_pal_valid, b_is_pal;
  logic [7:0] b_out_data;
  logic [LW8-1:0] b_len;

  logic m_in_ready, m_out_valid, m_out_last, m_ovf, m_pal_valid, m_is_pal;
  logic [7:0] m_out_data;
  logic [LW-1:0] m_len;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  str_stream_engine dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & ~use8), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
    .mode(mode_r), .case_fold(case_fold_r), .rot_k(rot_k_r),
    .out_valid(a_out_valid), .out_ready(out_ready & ~use8), .out_data(a_out_data),
    .out_last(a_out_last), .len_o(a_len), .overflow(a_ovf),
    .pal_valid(a_pal_valid), .is_pal(a_is_pal)
  );

  str_stream_engine #(.MAX_LEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid & use8), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
    .mode(mode_r), .case_fold(case_fold_r), .rot_k(rot_k_r[LW8-1:0]),
    .out_valid(b_out_valid), .out_ready(out_ready & use8), .out_data(b_out_data),
    .out_last(b_out_last), .len_o(b_len), .overflow(b_ovf),
    .pal_valid(b_pal_valid), .is_pal(b_is_pal)
  );

  assign m_in_ready  = use8 ? b_in_ready  : a_in_ready;
  assign m_out_valid = use8 ? b_out_valid : a_out_valid;
  assign m_out_data  = use8 ? b_out_data  : a_out_data;
  assign m_out_last  = use8 ? b_out_last  : a_out_last;
  assign m_len       = use8 ? {2'b00, b_len} : a_len;
  assign m_ovf       = use8 ? b_ovf       : a_ovf;
  assign m_pal_valid = use8 ? b_pal_valid : a_pal_valid;
  assign m_is_pal    = use8 ? b_is_pal    : a_is_pal;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Controls are only meaningful on the first byte; later bytes carry
  // random controls, which the DUT must ignore.
  task automatic send_str(input string s, input logic [1:0] md, input logic fold,
                          input logic [LW-1:0] k);
    for (int i = 0; i < s.len(); i++) begin
      if (i == 0) begin
        mode_r = md; case_fold_r = fold; rot_k_r = k;
        check("in_ready_load", 32'(m_in_ready), 32'd1);
      end else begin
        mode_r = 2'($urandom_range(0, 3));
        case_fold_r = 1'($urandom_range(0, 1));
        rot_k_r = LW'($urandom_range(0, 31));
      end
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = (i == s.len() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Number of edges, counting the in_last-accepting edge as 1, until the
  // selected output (out_valid or pal_valid) is seen.
  task automatic wait_first(input bit pal, output int n);
    n = 1;
    while (!(pal ? m_pal_valid : m_out_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic push_exp(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Consume nbytes from the output; toggle stalls every other cycle.
  task automatic recv(input int nbytes, input bit toggle);
    int got = 0;
    int budget = 0;
    bit rdy;
    while (got < nbytes && budget < 200) begin
      rdy = toggle ? (budget % 2 == 0) : 1'b1;
      out_ready = rdy;
      if (m_out_valid) begin
        check("out_data", 32'(m_out_data), 32'(exp_q[0]));
        check("out_last", 32'(m_out_last), 32'(exp_q.size() == 1));
        if (rdy) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
      @(negedge clk);
      budget++;
    end
    check("recv_count", 32'(got), 32'(nbytes));
    out_ready = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    mode_r = 2'd0; case_fold_r = 1'b0; rot_k_r = '0; out_ready = 1'b1; use8 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_in_ready", 32'(m_in_ready), 32'd1);
    check("rst_out_valid", 32'(m_out_valid), 32'd0);
    check("rst_out_data", 32'(m_out_data), 32'd0);
    check("rst_out_last", 32'(m_out_last), 32'd0);
    check("rst_len", 32'(m_len), 32'd0);
    check("rst_ovf", 32'(m_ovf), 32'd0);
    check("rst_pal_valid", 32'(m_pal_valid), 32'd0);
    check("rst_is_pal", 32'(m_is_pal), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mode 0 with case folding
    send_str("HeLLo", 2'd0, 1'b1, '0);
    wait_first(1'b0, n);
    check("m0_latency", 32'(n), 32'd1);
    check("m0_in_ready_busy", 32'(m_in_ready), 32'd0);
    check("m0_len", 32'(m_len), 32'd5);
    check("m0_ovf", 32'(m_ovf), 32'd0);
    push_exp("hello");
    recv(5, 1'b0);
    check("m0_in_ready_back", 32'(m_in_ready), 32'd1);
    check("m0_out_valid_done", 32'(m_out_valid), 32'd0);

    // Mode 1 with a stalling consumer
    send_str("System Verilog", 2'd1, 1'b0, '0);
    wait_first(1'b0, n);
    check("m1_latency", 32'(n), 32'd1);
    check("m1_len", 32'(m_len), 32'd14);
    push_exp("golireV metsyS");
    recv(14, 1'b1);

    // Mode 2 rotate: k=2, then k=8 (8 mod 6 = 2)
    send_str("Hello!", 2'd2, 1'b0, LW'(2));
    wait_first(1'b0, n);
    check("m2_k2_latency", 32'(n), 32'd2);
    push_exp("llo!He");
    recv(6, 1'b0);
    send_str("Hello!", 2'd2, 1'b0, LW'(8));
    wait_first(1'b0, n);
    check("m2_k8_latency", 32'(n), 32'd3);
    push_exp("llo!He");
    recv(6, 1'b0);

    // Mode 3 palindrome checks
    send_str("Madam", 2'd3, 1'b1, '0);
    wait_first(1'b1, n);
    check("pal_madam_fold_lat", 32'(n), 32'd4);
    check("pal_madam_fold", 32'(m_is_pal), 32'd1);
    check("pal_in_ready", 32'(m_in_ready), 32'd1);
    @(negedge clk);
    check("pal_strobe_one", 32'(m_pal_valid), 32'd0);
    check("pal_held", 32'(m_is_pal), 32'd1);

    send_str("Madam", 2'd3, 1'b0, '0);
    wait_first(1'b1, n);
    check("pal_madam_raw_lat", 32'(n), 32'd2);
    check("pal_madam_raw", 32'(m_is_pal), 32'd0);
    @(negedge clk);
    check("pal_strobe_two", 32'(m_pal_valid), 32'd0);

    send_str("a", 2'd3, 1'b0, '0);
    wait_first(1'b1, n);
    check("pal_a_lat", 32'(n), 32'd2);
    check("pal_a", 32'(m_is_pal), 32'd1);
    check("pal_a_len", 32'(m_len), 32'd1);
    @(negedge clk);
    check("pal_strobe_three", 32'(m_pal_valid), 32'd0);

    send_str("ab", 2'd3, 1'b0, '0);
    wait_first(1'b1, n);
    check("pal_ab_lat", 32'(n), 32'd2);
    check("pal_ab", 32'(m_is_pal), 32'd0);
    @(negedge clk);
    check("pal_strobe_four", 32'(m_pal_valid), 32'd0);

    // Truncation on the MAX_LEN=8 instance
    use8 = 1'b1;
    @(negedge clk);
    send_str("abcdefghij", 2'd0, 1'b0, '0);
    wait_first(1'b0, n);
    check("ovf_len", 32'(m_len), 32'd8);
    check("ovf_flag", 32'(m_ovf), 32'd1);
    push_exp("abcdefgh");
    recv(8, 1'b0);
    send_str("xy", 2'd0, 1'b0, '0);
    check("ovf_clear", 32'(m_ovf), 32'd0);
    check("ovf_next_len", 32'(m_len), 32'd2);
    wait_first(1'b0, n);
    push_exp("xy");
    recv(2, 1'b0);
    use8 = 1'b0;
    @(negedge clk);

    // Reset during EMIT, then a fresh reverse
    send_str("Hello", 2'd0, 1'b0, '0);
    wait_first(1'b0, n);
    push_exp("Hello");
    recv(2, 1'b0);
    check("pre_rst_data", 32'(m_out_data), 32'h6C);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(m_out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(m_in_ready), 32'd1);
    check("rst_mid_out_data", 32'(m_out_data), 32'd0);
    check("rst_mid_len", 32'(m_len), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_str("abc", 2'd1, 1'b0, '0);
    wait_first(1'b0, n);
    check("post_rst_latency", 32'(n), 32'd1);
    push_exp("cba");
    recv(3, 1'b0);
    check("post_rst_pal_valid", 32'(m_pal_valid), 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
